color_round_ctrl: RTL

Game-round controller that sits directly downstream of the random color generator. It requests a new color through `change`, latches the generated 3-bit color as the round target, and shows it on the RGB LED. It then collects and checks the player's guess, and keeps score and lives. Its `change` output drives the generator's `change` input; its `color` input is the generator's `color` output.

---
 rtl/color_round_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/color_round_ctrl.sv
// Round controller for the color-guessing game: requests a target from the random
// generator, shows it, judges the player's guess and keeps score and lives.
module color_round_ctrl #(
    parameter int CHANGE_CYCLES = 50_000_000,
    parameter int SHOW_CYCLES   = 50_000_000,
    parameter int GUESS_CYCLES  = 150_000_000,
    parameter int RESULT_CYCLES = 50_000_000,
    parameter int LIVES         = 3,
    parameter int MAX_SCORE     = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [2:0] guess,
    input  logic [2:0] color,
    output logic       change,
    output logic [2:0] led_rgb,
    output logic [6:0] score,
    output logic [1:0] lives,
    output logic       hit,
    output logic       miss,
    output logic       game_over
);

    localparam int MAX_AB  = (CHANGE_CYCLES > SHOW_CYCLES) ? CHANGE_CYCLES : SHOW_CYCLES;
    localparam int MAX_CD  = (GUESS_CYCLES > RESULT_CYCLES) ? GUESS_CYCLES : RESULT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] LD_CHANGE = TW'(CHANGE_CYCLES - 1);
    localparam logic [TW-1:0] LD_SHOW   = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] LD_GUESS  = TW'(GUESS_CYCLES - 1);
    localparam logic [TW-1:0] LD_RESULT = TW'(RESULT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NEXT   = 3'd1,
        S_SHOW   = 3'd2,
        S_GUESS  = 3'd3,
        S_HIT    = 3'd4,
        S_MISS   = 3'd5,
        S_RESULT = 3'd6,
        S_OVER   = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    target_q, target_d;
    logic [6:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic          start_prev_q, start_prev_d;
    logic          submit_prev_q, submit_prev_d;
    logic          change_q, change_d;
    logic [2:0]    led_q, led_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic          over_q, over_d;
    logic          start_rise_s, submit_rise_s, expired_s;

    // Next-state, timer, score/lives and registered-output computation
    always_comb begin
        state_d       = state_q;
        timer_d       = (timer_q != {TW{1'b0}}) ? (timer_q - TW'(1)) : timer_q;
        target_d      = target_q;
        score_d       = score_q;
        lives_d       = lives_q;
        start_prev_d  = start;
        submit_prev_d = submit;
        start_rise_s  = start & ~start_prev_q;
        submit_rise_s = submit & ~submit_prev_q;
        expired_s     = (timer_q == {TW{1'b0}});

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise_s) begin
                    state_d = S_NEXT;
                    timer_d = LD_CHANGE;
                    score_d = 7'd0;
                    lives_d = 2'(LIVES);
                end else begin
                    state_d = state_q;
                end
            end
            S_NEXT: begin
                if (expired_s) begin
                    target_d = color;
                    // Black is never a valid target: request another color.
                    if (color == 3'b000) begin
                        timer_d = LD_CHANGE;
                    end else begin
                        state_d = S_SHOW;
                        timer_d = LD_SHOW;
                    end
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_SHOW: begin
                if (expired_s) begin
                    state_d = S_GUESS;
                    timer_d = LD_GUESS;
                end else begin
                    state_d = S_SHOW;
                end
            end
            S_GUESS: begin
                if (submit_rise_s) begin
                    state_d = (guess == target_q) ? S_HIT : S_MISS;
                    timer_d = {TW{1'b0}};
                end else if (expired_s) begin
                    state_d = S_MISS;
                    timer_d = {TW{1'b0}};
                end else begin
                    state_d = S_GUESS;
                end
            end
            S_HIT: begin
                score_d = (score_q >= 7'(MAX_SCORE)) ? 7'(MAX_SCORE) : (score_q + 7'd1);
                state_d = S_RESULT;
                timer_d = LD_RESULT;
            end
            S_MISS: begin
                lives_d = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
                if (lives_q <= 2'd1) begin
                    state_d = S_OVER;
                end else begin
                    state_d = S_RESULT;
                    timer_d = LD_RESULT;
                end
            end
            S_RESULT: begin
                if (expired_s) begin
                    state_d = S_NEXT;
                    timer_d = LD_CHANGE;
                end else begin
                    state_d = S_RESULT;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = {TW{1'b0}};
            end
        endcase

        change_d = (state_q == S_NEXT);
        hit_d    = (state_q == S_HIT);
        miss_d   = (state_q == S_MISS);
        over_d   = (state_q == S_OVER);
        case (state_q)
            S_SHOW, S_RESULT: led_d = target_q;
            S_OVER:           led_d = 3'b111;
            default:          led_d = 3'b000;
        endcase
    end

    // State, timer, game data and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            timer_q       <= {TW{1'b0}};
            target_q      <= 3'b000;
            score_q       <= 7'd0;
            lives_q       <= 2'(LIVES);
            start_prev_q  <= 1'b0;
            submit_prev_q <= 1'b0;
            change_q      <= 1'b0;
            led_q         <= 3'b000;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            over_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            target_q      <= target_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            start_prev_q  <= start_prev_d;
            submit_prev_q <= submit_prev_d;
            change_q      <= change_d;
            led_q         <= led_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
            over_q        <= over_d;
        end
    end

    assign change    = change_q;
    assign led_rgb   = led_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign game_over = over_q;

endmodule
